// File: rtl/mb16_pkg.sv
// mb16_pkg -- shared definitions for the multiplier-based processing element.
//
// Contents:
//   state_e   : accumulator FSM states (IDLE, ACCUM, DRAIN)
//   *_DEF     : default WIDTH / ACC_W / CNT_W values
//   sat_add   : clamp helper. Only referenced when MB16_ACC_SAT_EN is defined.
//
// Optional feature macro: MB16_ACC_SAT_EN (saturating accumulation).
package mb16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    // Wide enough to carry any accumulator width this block is built with.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Resolve the result of a w-bit signed add. On overflow the result
    // clamps to the extreme value on the side of the (equal) addend signs.
    // Only the low w bits of the return value are meaningful.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] sum,
        input logic                 ovf,
        input logic                 addend_neg,
        input int                   w
    );
        logic [SAT_MAX_W-1:0] min_v;
        // 1 at bit w-1 and above: the most negative w-bit value once truncated
        min_v = {SAT_MAX_W{1'b1}} << (w - 1);
        if (!ovf) begin
            return sum;
        end else if (addend_neg) begin
            return min_v;
        end else begin
            return ~min_v;
        end
    endfunction

endpackage

// File: rtl/mb16_acc_add.sv
// mb16_acc_add -- combinational sign-extend + add + signed-overflow detect.
//
// Ports:
//   a_i   [ACC_W-1:0] accumulator operand (two's complement)
//   b_i   [PW-1:0]    product operand, sign-extended to ACC_W before the add
//   sum_o [ACC_W-1:0] result: wrapped, or clamped when MB16_ACC_SAT_EN is set
//   ovf_o             signed overflow of this add
//
// Optional feature macro: MB16_ACC_SAT_EN (clamp instead of wrap on overflow).
module mb16_acc_add
    import mb16_pkg::*;
#(
    parameter int PW    = 32,
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [PW-1:0]    b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] raw;

    assign b_ext = {{(ACC_W - PW){b_i[PW-1]}}, b_i};
    assign raw   = a_i + b_ext;

    // Overflow: both addends share a sign and the result sign differs.
    assign ovf_o = (a_i[ACC_W-1] == b_ext[ACC_W-1]) &&
                   (raw[ACC_W-1] != a_i[ACC_W-1]);

`ifdef MB16_ACC_SAT_EN
    assign sum_o = ACC_W'(sat_add(SAT_MAX_W'(raw), ovf_o, a_i[ACC_W-1], ACC_W));
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/mb16_mac_acc.sv
// mb16_mac_acc -- accumulates groups of signed products from the Booth
// multiplier into a wide sum and presents each finished group downstream.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   prod_valid/ready    product input handshake
//   product [2*WIDTH]   signed product
//   prod_last           marks the accepted product as the last of its group
//   acc_valid/ready     result output handshake
//   acc_out [ACC_W]     signed group sum
//   acc_count [CNT_W]   products in the group (saturates at all-ones)
//   overflow            group overflowed ACC_W (sticky within the group)
//   busy                a group is in progress
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. prod_ready depends on state only (low during DRAIN). Once
// acc_valid is high, acc_out/acc_count/overflow stay stable until the
// transfer edge; acc_out keeps its value afterwards until the next group.
//
// Optional feature macro: MB16_ACC_SAT_EN (saturating accumulator).
module mb16_mac_acc
    import mb16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               prod_valid,
    output logic               prod_ready,
    input  logic [2*WIDTH-1:0] product,
    input  logic               prod_last,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]   acc_count,
    output logic               overflow,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] acc_d;
    logic             add_ovf;
    logic             accept;

    assign prod_ready = (state_q != DRAIN);
    assign busy       = (state_q == ACCUM);
    assign accept     = prod_valid && prod_ready;

    // The first product of a group is added to zero, which is exactly a
    // sign-extended load and can never overflow.
    assign add_a = (state_q == ACCUM) ? acc_q : '0;

    mb16_acc_add #(
        .PW    (PW),
        .ACC_W (ACC_W)
    ) u_add (
        .a_i   (add_a),
        .b_i   (product),
        .sum_o (acc_d),
        .ovf_o (add_ovf)
    );

    always_comb begin
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
        if (state_q == ACCUM) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out   <= '0;
            acc_count <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (prod_last) begin
                            // Result registers capture the sum including
                            // this last product.
                            state_q   <= DRAIN;
                            acc_out   <= acc_d;
                            acc_count <= cnt_d;
                            overflow  <= ovf_d;
                            acc_valid <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (acc_ready) begin
                        acc_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb16_mac_acc.sv
// tb_mb16_mac_acc -- directed bench for mb16_mac_acc (ACC_W=33, CNT_W=4 so
// overflow and count saturation are reachable). A group-level model
// predicts every result; a per-cycle compare process checks the DUT
// against it, and directed checks pin the model with literal values.
// Build with MB16_ACC_SAT_EN defined to check the clamping variant.
module tb_mb16_mac_acc;

    localparam int WIDTH = 16;
    localparam int ACC_W = 33;
    localparam int CNT_W = 4;
    localparam int PW    = 2 * WIDTH;
    localparam int EW    = ACC_W + CNT_W + 1;

    localparam longint ACC_HI = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_LO = -(longint'(1) <<< (ACC_W - 1));
    localparam longint SPAN   = longint'(1) <<< ACC_W;
    localparam int     CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic [PW-1:0]    product = '0;
    logic             prod_last = 1'b0;
    logic             acc_valid;
    logic             acc_ready = 1'b1;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_count;
    logic             overflow;
    logic             busy;

    always #5 CLK = ~CLK;

    mb16_mac_acc #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .product    (product),
        .prod_last  (prod_last),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_out    (acc_out),
        .acc_count  (acc_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- group-level model ----------------
    // Entries are {overflow, count, sum}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_last = '0;
    bit            m_in_group = 1'b0;
    bit            m_pending  = 1'b0;
    longint        m_acc = 0;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;

    always @(posedge CLK or negedge RST) begin : model
        longint p;
        longint t;
        bit     pend0;
        if (!RST) begin
            m_in_group = 1'b0;
            m_pending  = 1'b0;
            exp_q.delete();
            m_last     = '0;
        end else begin
            pend0 = m_pending;
            if (m_pending && acc_ready) begin
                m_last    = exp_q.pop_front();
                m_pending = 1'b0;
            end
            if (prod_valid && !pend0) begin
                p = longint'($signed(product));
                if (!m_in_group) begin
                    m_acc = p;
                    m_cnt = 1;
                    m_ovf = 1'b0;
                end else begin
                    t = m_acc + p;
                    if (t > ACC_HI || t < ACC_LO) begin
                        m_ovf = 1'b1;
`ifdef MB16_ACC_SAT_EN
                        t = (t > ACC_HI) ? ACC_HI : ACC_LO;
`else
                        t = (t > ACC_HI) ? t - SPAN : t + SPAN;
`endif
                    end
                    m_acc = t;
                    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                end
                if (prod_last) begin
                    exp_q.push_back({m_ovf, CNT_W'(m_cnt), ACC_W'(m_acc)});
                    m_pending  = 1'b1;
                    m_in_group = 1'b0;
                end else begin
                    m_in_group = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (chk_en) begin
            e = m_pending ? exp_q[0] : m_last;
            chk("cyc_prod_ready", prod_ready, !m_pending);
            chk("cyc_busy", busy, m_in_group);
            chk("cyc_acc_valid", acc_valid, m_pending);
            chk("cyc_acc_out", acc_out, e[ACC_W-1:0]);
            chk("cyc_acc_count", acc_count, e[ACC_W+CNT_W-1:ACC_W]);
            chk("cyc_overflow", overflow, e[EW-1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [PW-1:0] p, input logic last);
        int n = 0;
        prod_valid = 1'b1;
        product    = p;
        prod_last  = last;
        while (!prod_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("send_accept", prod_ready, 1'b1);
        @(posedge CLK);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [ACC_W-1:0] a,
                               input logic [CNT_W-1:0] c, input logic o);
        int n = 0;
        while (!acc_valid && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({name, "_valid"}, acc_valid, 1'b1);
        chk({name, "_acc"}, acc_out, a);
        chk({name, "_cnt"}, acc_count, c);
        chk({name, "_ovf"}, overflow, o);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset state
        RST = 1'b0;
        idle(3);
        chk("rst_valid", acc_valid, 1'b0);
        chk("rst_acc", acc_out, '0);
        chk("rst_cnt", acc_count, '0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        RST = 1'b1;
        chk_en = 1'b1;
        idle(1);
        chk("rst_ready", prod_ready, 1'b1);

        // Reset in the middle of a group clears a previously shown result too
        send(32'd9, 1'b1);
        wait_result("pre", 33'd9, 4'd1, 1'b0);
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        chk("mid_busy", busy, 1'b1);
        RST = 1'b0;
        #2;
        chk("mid_rst_acc", acc_out, '0);
        chk("mid_rst_cnt", acc_count, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", acc_valid, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        chk("mid_ready", prod_ready, 1'b1);
        send(32'd7, 1'b1);
        wait_result("after_rst", 33'd7, 4'd1, 1'b0);

        // Four-product group: 1000 - 3000 + 65025 - 1 = 63024
        send(32'd1000, 1'b0);
        send(32'hFFFF_F448, 1'b0);
        send(32'd65025, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        wait_result("four", 33'd63024, 4'd4, 1'b0);
        idle(1);
        chk("four_pulse", acc_valid, 1'b0);

        // Backpressure: result held while acc_ready is low
        acc_ready = 1'b0;
        send(32'd5, 1'b0);
        send(32'd6, 1'b1);
        wait_result("bp", 33'd11, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("bp_hold_acc", acc_out, 33'd11);
            chk("bp_hold_ready", prod_ready, 1'b0);
        end
        acc_ready = 1'b1;
        idle(1);
        chk("bp_release_valid", acc_valid, 1'b0);
        chk("bp_release_ready", prod_ready, 1'b1);
        send(32'd1, 1'b1);
        wait_result("bp_next", 33'd1, 4'd1, 1'b0);

        // Bubbles, plus prod_last without prod_valid must be ignored
        send(32'd1, 1'b0);
        prod_last = 1'b1;
        idle(2);
        chk("bubble_busy", busy, 1'b1);
        prod_last = 1'b0;
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        wait_result("bubble", 33'd6, 4'd3, 1'b0);

        // Positive overflow
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 1'b1);
`ifdef MB16_ACC_SAT_EN
        wait_result("povf", 33'h0_FFFF_FFFF, 4'd3, 1'b1);
`else
        wait_result("povf", 33'h1_7FFF_FFFD, 4'd3, 1'b1);
`endif
        // Next group starts with overflow cleared
        send(32'hFFFF_FFFB, 1'b1);
        wait_result("ovf_clear", 33'h1_FFFF_FFFB, 4'd1, 1'b0);

        // Negative overflow: 3 * -2^31 is below -2^32
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b1);
`ifdef MB16_ACC_SAT_EN
        wait_result("novf", 33'h1_0000_0000, 4'd3, 1'b1);
`else
        wait_result("novf", 33'h0_8000_0000, 4'd3, 1'b1);
`endif

        // Count saturation: 20 products of 1
        for (int i = 0; i < 20; i++) begin
            send(32'd1, (i == 19));
        end
        wait_result("cnt_sat", 33'd20, 4'd15, 1'b0);

        idle(3);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
